// File: rtl/nanorv32_wb_stage.sv
// Write-back stage: registered ALU results on regfile port 1, aligned load data on port 2,
// one outstanding load, and read-after-write hazard reporting back to decode.
module nanorv32_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [SEL_W-1:0]  alu_rd_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              ld_issue,
  input  logic [SEL_W-1:0]  ld_rd_sel,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lsb,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [SEL_W-1:0]  sel_porta,
  input  logic [SEL_W-1:0]  sel_portb,
  output logic [SEL_W-1:0]  sel_rd,
  output logic [DATA_W-1:0] rd,
  output logic              write_rd,
  output logic [SEL_W-1:0]  sel_rd2,
  output logic [DATA_W-1:0] rd2,
  output logic              write_rd2,
  output logic              ld_ready,
  output logic              load_pending,
  output logic              hazard,
  output logic              wb_err
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e            r_state, w_state_d;
  logic [SEL_W-1:0]  r_ld_sel;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_lsb;
  logic [SEL_W-1:0]  r_sel_rd, r_sel_rd2;
  logic [DATA_W-1:0] r_rd, r_rd2;
  logic              r_write_rd, r_write_rd2, r_wb_err;

  logic              w_accept, w_complete, w_proto_err;
  logic              w_wr1, w_wr2;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_err;
  logic              w_haz_a, w_haz_b;

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_proto_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (ld_issue) begin
          w_accept  = 1'b1;
          w_state_d = StWait;
        end
        // A response with nothing outstanding is dropped.
        if (dmem_rvalid) w_proto_err = 1'b1;
      end
      StWait: begin
        if (dmem_rvalid) begin
          w_complete = 1'b1;
          w_state_d  = StIdle;
        end
        if (ld_issue) w_proto_err = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_byte    = dmem_rdata[8*r_ld_lsb +: 8];
    w_half    = r_ld_lsb[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld_data = dmem_rdata;
    w_ld_err  = 1'b0;
    case (r_ld_f3)
      3'b000: w_ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b100: w_ld_data = {{(DATA_W-8){1'b0}}, w_byte};
      3'b001: begin
        w_ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
        w_ld_err  = r_ld_lsb[0];
      end
      3'b101: begin
        w_ld_data = {{(DATA_W-16){1'b0}}, w_half};
        w_ld_err  = r_ld_lsb[0];
      end
      3'b010:  w_ld_err = (r_ld_lsb != 2'b00);
      default: w_ld_err = 1'b1;
    endcase
  end

  // On a same-register collision the younger ALU write wins.
  assign w_wr1 = alu_valid && (alu_rd_sel != '0);
  assign w_wr2 = w_complete && (r_ld_sel != '0) && !(w_wr1 && (alu_rd_sel == r_ld_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ld_sel    <= '0;
      r_ld_f3     <= '0;
      r_ld_lsb    <= '0;
      r_sel_rd    <= '0;
      r_rd        <= '0;
      r_write_rd  <= 1'b0;
      r_sel_rd2   <= '0;
      r_rd2       <= '0;
      r_write_rd2 <= 1'b0;
      r_wb_err    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_write_rd  <= w_wr1;
      r_write_rd2 <= w_wr2;
      r_wb_err    <= r_wb_err | w_proto_err | (w_complete & w_ld_err);
      if (w_accept) begin
        r_ld_sel <= ld_rd_sel;
        r_ld_f3  <= ld_funct3;
        r_ld_lsb <= ld_addr_lsb;
      end
      if (w_wr1) begin
        r_sel_rd <= alu_rd_sel;
        r_rd     <= alu_result;
      end
      if (w_wr2) begin
        r_sel_rd2 <= r_ld_sel;
        r_rd2     <= w_ld_data;
      end
    end
  end

  always_comb begin
    w_haz_a = (sel_porta != '0) &&
              (((r_state == StWait) && (sel_porta == r_ld_sel)) ||
               (r_write_rd && (sel_porta == r_sel_rd)) ||
               (r_write_rd2 && (sel_porta == r_sel_rd2)));
    w_haz_b = (sel_portb != '0) &&
              (((r_state == StWait) && (sel_portb == r_ld_sel)) ||
               (r_write_rd && (sel_portb == r_sel_rd)) ||
               (r_write_rd2 && (sel_portb == r_sel_rd2)));
  end

  assign sel_rd       = r_sel_rd;
  assign rd           = r_rd;
  assign write_rd     = r_write_rd;
  assign sel_rd2      = r_sel_rd2;
  assign rd2          = r_rd2;
  assign write_rd2    = r_write_rd2;
  // Held low while reset is asserted so every output reads 0 in reset.
  assign ld_ready     = rst_n && (r_state == StIdle);
  assign load_pending = (r_state == StWait);
  assign hazard       = w_haz_a || w_haz_b;
  assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_nanorv32_wb_stage.sv
// Directed bench for nanorv32_wb_stage with hand-computed expected values.
module tb_nanorv32_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd_sel;
  logic [31:0] alu_result;
  logic        ld_issue;
  logic [4:0]  ld_rd_sel;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lsb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  sel_porta, sel_portb;
  logic [4:0]  sel_rd, sel_rd2;
  logic [31:0] rd, rd2;
  logic        write_rd, write_rd2, ld_ready, load_pending, hazard, wb_err;

  int n_cmp = 0;
  int n_err = 0;

  nanorv32_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd_sel(alu_rd_sel), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_rd_sel(ld_rd_sel), .ld_funct3(ld_funct3),
    .ld_addr_lsb(ld_addr_lsb), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .sel_porta(sel_porta), .sel_portb(sel_portb),
    .sel_rd(sel_rd), .rd(rd), .write_rd(write_rd),
    .sel_rd2(sel_rd2), .rd2(rd2), .write_rd2(write_rd2),
    .ld_ready(ld_ready), .load_pending(load_pending), .hazard(hazard), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Issue a load, wait one cycle in WAIT, then deliver the response.
  task automatic do_load(input logic [4:0] sel, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] data);
    ld_issue = 1'b1; ld_rd_sel = sel; ld_funct3 = f3; ld_addr_lsb = lsb;
    step();
    ld_issue = 1'b0;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = data;
    step();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd_sel = '0; alu_result = '0;
    ld_issue = 1'b0; ld_rd_sel = '0; ld_funct3 = '0; ld_addr_lsb = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0; sel_porta = '0; sel_portb = '0;

    #12;
    chk("rst_write_rd", write_rd, 0);
    chk("rst_write_rd2", write_rd2, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_rd", rd, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_ld_ready", ld_ready, 1);
    chk("idle_pending", load_pending, 0);

    // ALU write to x5
    alu_valid = 1'b1; alu_rd_sel = 5'd5; alu_result = 32'h1234_5678; sel_porta = 5'd5;
    #1;
    chk("alu_haz_before", hazard, 0);
    step();
    alu_valid = 1'b0;
    chk("alu_write_rd", write_rd, 1);
    chk("alu_sel_rd", sel_rd, 5);
    chk("alu_rd", rd, 32'h1234_5678);
    chk("alu_hazard", hazard, 1);
    step();
    chk("alu_write_rd_off", write_rd, 0);
    chk("alu_rd_hold", rd, 32'h1234_5678);
    chk("alu_haz_clear", hazard, 0);
    sel_porta = '0;

    // LB x10, lsb 3
    ld_issue = 1'b1; ld_rd_sel = 5'd10; ld_funct3 = 3'b000; ld_addr_lsb = 2'd3;
    step();
    ld_issue = 1'b0;
    chk("lb_pending1", load_pending, 1);
    chk("lb_ready1", ld_ready, 0);
    step();
    chk("lb_pending2", load_pending, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    step();
    dmem_rvalid = 1'b0;
    chk("lb_write_rd2", write_rd2, 1);
    chk("lb_sel_rd2", sel_rd2, 10);
    chk("lb_rd2", rd2, 32'hFFFF_FF80);
    chk("lb_pending_off", load_pending, 0);
    chk("lb_ready", ld_ready, 1);
    step();
    chk("lb_write_rd2_off", write_rd2, 0);

    do_load(5'd10, 3'b100, 2'd3, 32'h80FF_0000);
    chk("lbu_rd2", rd2, 32'h0000_0080);
    chk("lbu_write_rd2", write_rd2, 1);

    do_load(5'd11, 3'b001, 2'd2, 32'h8001_7FFF);
    chk("lh_rd2", rd2, 32'hFFFF_8001);
    chk("lh_wb_err", wb_err, 0);

    do_load(5'd12, 3'b101, 2'd0, 32'h1234_F00D);
    chk("lhu_rd2", rd2, 32'h0000_F00D);

    do_load(5'd13, 3'b010, 2'd0, 32'hDEAD_BEEF);
    chk("lw_rd2", rd2, 32'hDEAD_BEEF);
    chk("lw_wb_err", wb_err, 0);

    do_load(5'd11, 3'b001, 2'd1, 32'h8001_7FFF);
    chk("lh_mis_write", write_rd2, 1);
    chk("lh_mis_rd2", rd2, 32'h0000_7FFF);
    chk("lh_mis_err", wb_err, 1);
    rst_pulse();
    chk("rst_clear_err", wb_err, 0);

    do_load(5'd14, 3'b011, 2'd0, 32'h0123_4567);
    chk("f3_011_rd2", rd2, 32'h0123_4567);
    chk("f3_011_err", wb_err, 1);
    rst_pulse();
    chk("rst_clear_err2", wb_err, 0);

    // Load to x7 pending, hazard on port B, then ALU/load collision on x7
    ld_issue = 1'b1; ld_rd_sel = 5'd7; ld_funct3 = 3'b010; ld_addr_lsb = 2'd0;
    step();
    ld_issue = 1'b0; sel_portb = 5'd7;
    #1;
    chk("x7_haz_wait1", hazard, 1);
    step();
    chk("x7_haz_wait2", hazard, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_5555;
    alu_valid = 1'b1; alu_rd_sel = 5'd7; alu_result = 32'h1111_1111;
    step();
    dmem_rvalid = 1'b0; alu_valid = 1'b0;
    chk("col_write_rd", write_rd, 1);
    chk("col_write_rd2", write_rd2, 0);
    chk("col_sel_rd", sel_rd, 7);
    chk("col_rd", rd, 32'h1111_1111);
    chk("col_hazard", hazard, 1);
    chk("col_err", wb_err, 0);
    sel_portb = '0;
    step();

    // Response with nothing outstanding
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5A5A_5A5A;
    step();
    dmem_rvalid = 1'b0;
    chk("idle_rv_write", write_rd2, 0);
    chk("idle_rv_err", wb_err, 1);
    chk("idle_rv_ready", ld_ready, 1);
    rst_pulse();
    chk("rst_pulse_err", wb_err, 0);

    // Load to x0 completes the handshake without a write or hazard
    ld_issue = 1'b1; ld_rd_sel = 5'd0; ld_funct3 = 3'b010; ld_addr_lsb = 2'd0;
    step();
    ld_issue = 1'b0;
    chk("x0_pending", load_pending, 1);
    chk("x0_ready", ld_ready, 0);
    chk("x0_haz_wait", hazard, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk("x0_write_rd2", write_rd2, 0);
    chk("x0_ready_back", ld_ready, 1);
    chk("x0_haz_after", hazard, 0);

    // Issue during WAIT together with the response: response completes, issue dropped
    ld_issue = 1'b1; ld_rd_sel = 5'd3; ld_funct3 = 3'b000; ld_addr_lsb = 2'd0;
    step();
    ld_rd_sel = 5'd4; ld_funct3 = 3'b010;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_00F0;
    step();
    ld_issue = 1'b0; dmem_rvalid = 1'b0;
    chk("dbl_write_rd2", write_rd2, 1);
    chk("dbl_sel_rd2", sel_rd2, 3);
    chk("dbl_rd2", rd2, 32'hFFFF_FFF0);
    chk("dbl_ready", ld_ready, 1);
    chk("dbl_err", wb_err, 1);
    rst_pulse();

    // Reset mid-load abandons it; the late response is a protocol error
    ld_issue = 1'b1; ld_rd_sel = 5'd9; ld_funct3 = 3'b010; ld_addr_lsb = 2'd0;
    step();
    ld_issue = 1'b0;
    chk("mid_pending", load_pending, 1);
    rst_pulse();
    chk("mid_abandon", load_pending, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_rvalid = 1'b0;
    chk("mid_late_write", write_rd2, 0);
    chk("mid_late_err", wb_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
